// File: rtl/systolic_feeder_if.sv
// Feeder bus: chunk handshake in, skewed per-lane words and tile markers out.
interface systolic_feeder_if #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH*CHUNK_SIZE-1:0]   input_w;
  logic [WIDTH*CHUNK_SIZE-1:0]   input_n;
  logic [WIDTH*BLOCK_SIZE-1:0]   out_w;
  logic [WIDTH*BLOCK_SIZE-1:0]   out_n;
  logic [BLOCK_SIZE-1:0]         out_valid;
  logic [BLOCK_SIZE-1:0]         out_first;
  logic [BLOCK_SIZE-1:0]         out_last;
  logic                          tile_done;

  modport master (
    output in_valid, input_w, input_n,
    input  in_ready, out_w, out_n, out_valid, out_first, out_last, tile_done
  );

  modport slave (
    input  in_valid, input_w, input_n,
    output in_ready, out_w, out_n, out_valid, out_first, out_last, tile_done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Serialises west/north chunks into BLOCK_SIZE skewed lanes; lane i word j appears 1+i+j cycles after accept.
// Backpressure: in_ready is registered and drops while a chunk is mid-serialisation (up on the last phase).
module systolic_feeder #(
  parameter int WIDTH           = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int CHUNK_SIZE      = 4,
  parameter int INNER_DIMENSION = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave feed_if
);

  localparam int RATIO = CHUNK_SIZE / BLOCK_SIZE;
  localparam int CPT   = INNER_DIMENSION / RATIO;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CW    = (CPT > 1) ? $clog2(CPT) : 1;
  localparam int CHW   = WIDTH * CHUNK_SIZE;
  localparam logic [PW-1:0] LAST_PH = PW'(RATIO - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(CPT - 1);

  if (CHUNK_SIZE % BLOCK_SIZE != 0) begin : g_bad_chunk
    $error("CHUNK_SIZE must be a multiple of BLOCK_SIZE");
  end
  if (INNER_DIMENSION % RATIO != 0) begin : g_bad_inner
    $error("INNER_DIMENSION must be a multiple of CHUNK_SIZE/BLOCK_SIZE");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH cannot exceed WIDTH");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] n;
    logic             vld;
    logic             first;
    logic             last;
  } lane_t;

  state_t          state_q;
  logic [PW-1:0]   phase_q;
  logic            rdy_q;
  logic [CHW-1:0]  w_hold_q;
  logic [CHW-1:0]  n_hold_q;
  logic [CW-1:0]   cur_cnt_q;
  logic [CW-1:0]   nxt_cnt_q;
  logic            accept;

  assign accept          = feed_if.in_valid & rdy_q;
  assign feed_if.in_ready = rdy_q;

  // Holding regs reload on the same edge the previous chunk's last phase is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      rdy_q     <= 1'b0;
      w_hold_q  <= '0;
      n_hold_q  <= '0;
      cur_cnt_q <= '0;
      nxt_cnt_q <= '0;
    end else begin
      if (accept) begin
        w_hold_q  <= feed_if.input_w;
        n_hold_q  <= feed_if.input_n;
        cur_cnt_q <= nxt_cnt_q;
        nxt_cnt_q <= (nxt_cnt_q == LAST_CH) ? '0 : nxt_cnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= STREAM;
            phase_q <= '0;
            rdy_q   <= (RATIO == 1);
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        STREAM: begin
          if (phase_q != LAST_PH) begin
            phase_q <= phase_q + 1'b1;
            rdy_q   <= ((phase_q + 1'b1) == LAST_PH);
          end else if (accept) begin
            phase_q <= '0;
            rdy_q   <= (RATIO == 1);
          end else begin
            state_q <= IDLE;
            phase_q <= '0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lane_t ser [BLOCK_SIZE];

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      ser[i] = '0;
      if (state_q == STREAM) begin
        ser[i].w     = w_hold_q[CHW-1 - WIDTH*(i*RATIO + int'(phase_q)) -: WIDTH];
        ser[i].n     = n_hold_q[CHW-1 - WIDTH*(i*RATIO + int'(phase_q)) -: WIDTH];
        ser[i].vld   = 1'b1;
        ser[i].first = (cur_cnt_q == '0) && (phase_q == '0);
        ser[i].last  = (cur_cnt_q == LAST_CH) && (phase_q == LAST_PH);
      end
    end
  end

  logic [BLOCK_SIZE-1:0] vld_v;
  logic [BLOCK_SIZE-1:0] last_v;

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    // Stage 0 is the serialiser register; lane i adds i more stages of skew.
    lane_t pipe_q [0:i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= i; d++) pipe_q[d] <= '0;
      end else begin
        pipe_q[0] <= ser[i];
        for (int d = 1; d <= i; d++) pipe_q[d] <= pipe_q[d-1];
      end
    end

    assign feed_if.out_w[WIDTH*(BLOCK_SIZE-i)-1 -: WIDTH] = pipe_q[i].w;
    assign feed_if.out_n[WIDTH*(BLOCK_SIZE-i)-1 -: WIDTH] = pipe_q[i].n;
    assign vld_v[i]                = pipe_q[i].vld;
    assign last_v[i]               = pipe_q[i].last;
    assign feed_if.out_first[i]    = pipe_q[i].first;
  end

  assign feed_if.out_valid = vld_v;
  assign feed_if.out_last  = last_v;
  assign feed_if.tile_done = vld_v[BLOCK_SIZE-1] & last_v[BLOCK_SIZE-1];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table plus hand sequences for the skewed operand feeder (2-lane and 4-lane builds).
module tb_systolic_feeder;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miss_cnt;

  systolic_feeder_if #(.WIDTH(16), .BLOCK_SIZE(2), .CHUNK_SIZE(4)) bus ();
  systolic_feeder_if #(.WIDTH(16), .BLOCK_SIZE(4), .CHUNK_SIZE(8)) b4 ();

  systolic_feeder #(
    .WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .CHUNK_SIZE(4), .INNER_DIMENSION(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .feed_if(bus)
  );

  systolic_feeder #(
    .WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(4), .CHUNK_SIZE(8), .INNER_DIMENSION(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .feed_if(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] w;
    logic        rdy;
    logic [31:0] ow;
    logic [1:0]  ov;
    logic [1:0]  of;
    logic [1:0]  ol;
    logic        td;
  } vec_t;

  localparam logic [63:0] CA    = 64'h0001_0002_0003_0004;
  localparam logic [63:0] CB    = 64'h0005_0006_0007_0008;
  localparam logic [63:0] CC    = 64'h0009_000A_000B_000C;
  localparam logic [63:0] CD    = 64'h000D_000E_000F_0010;
  localparam logic [63:0] GB    = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] NMASK = 64'h1000_1000_1000_1000;

  vec_t tbl [14];

  function automatic vec_t row(logic iv, logic [63:0] w, logic rdy, logic [31:0] ow,
                               logic [1:0] ov, logic [1:0] of, logic [1:0] ol, logic td);
    vec_t r;
    r.iv = iv; r.w = w; r.rdy = rdy; r.ow = ow;
    r.ov = ov; r.of = of; r.ol = ol; r.td = td;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  exp_on;
    logic [127:0] w8;
    vec_cnt  = 0;
    miss_cnt = 0;

    tbl[0]  = row(1'b1, CA, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1'b0);
    tbl[1]  = row(1'b0, '0, 1'b0, 32'h0001_0000, 2'b01, 2'b01, 2'b00, 1'b0);
    tbl[2]  = row(1'b0, '0, 1'b1, 32'h0002_0003, 2'b11, 2'b10, 2'b00, 1'b0);
    tbl[3]  = row(1'b0, '0, 1'b1, 32'h0000_0004, 2'b10, 2'b00, 2'b00, 1'b0);
    tbl[4]  = row(1'b0, '0, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1'b0);
    tbl[5]  = row(1'b1, CB, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1'b0);
    tbl[6]  = row(1'b1, GB, 1'b0, 32'h0005_0000, 2'b01, 2'b00, 2'b00, 1'b0);
    tbl[7]  = row(1'b1, CC, 1'b1, 32'h0006_0007, 2'b11, 2'b00, 2'b01, 1'b0);
    tbl[8]  = row(1'b1, GB, 1'b0, 32'h0009_0008, 2'b11, 2'b01, 2'b10, 1'b1);
    tbl[9]  = row(1'b1, CD, 1'b1, 32'h000A_000B, 2'b11, 2'b10, 2'b00, 1'b0);
    tbl[10] = row(1'b0, '0, 1'b0, 32'h000D_000C, 2'b11, 2'b00, 2'b00, 1'b0);
    tbl[11] = row(1'b0, '0, 1'b1, 32'h000E_000F, 2'b11, 2'b00, 2'b01, 1'b0);
    tbl[12] = row(1'b0, '0, 1'b1, 32'h0000_0010, 2'b10, 2'b00, 2'b10, 1'b1);
    tbl[13] = row(1'b0, '0, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1'b0);

    rst_n       = 1'b0;
    bus.in_valid = 1'b0;
    bus.input_w  = '0;
    bus.input_n  = '0;
    b4.in_valid  = 1'b0;
    b4.input_w   = '0;
    b4.input_n   = '0;

    // Reset state.
    #12;
    chk("rst_ready", 64'(bus.in_ready), 64'(1'b0));
    chk("rst_out_w", 64'(bus.out_w), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_flags", 64'({bus.out_first, bus.out_last, bus.tile_done}), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // Single chunk, gapped second chunk, back-to-back tile, hold check.
    for (int k = 0; k < 14; k++) begin
      bus.in_valid = tbl[k].iv;
      bus.input_w  = tbl[k].w;
      bus.input_n  = tbl[k].w ^ NMASK;
      chk($sformatf("v%0d_ready", k), 64'(bus.in_ready), 64'(tbl[k].rdy));
      @(posedge clk) #1;
      exp_on = tbl[k].ow ^ {tbl[k].ov[0] ? 16'h1000 : 16'h0000,
                            tbl[k].ov[1] ? 16'h1000 : 16'h0000};
      chk($sformatf("v%0d_out_w", k),  64'(bus.out_w),     64'(tbl[k].ow));
      chk($sformatf("v%0d_out_n", k),  64'(bus.out_n),     64'(exp_on));
      chk($sformatf("v%0d_valid", k),  64'(bus.out_valid), 64'(tbl[k].ov));
      chk($sformatf("v%0d_first", k),  64'(bus.out_first), 64'(tbl[k].of));
      chk($sformatf("v%0d_last", k),   64'(bus.out_last),  64'(tbl[k].ol));
      chk($sformatf("v%0d_tdone", k),  64'(bus.tile_done), 64'(tbl[k].td));
    end

    // Reset mid-tile: chunk E starts a tile, reset aborts it, chunk F must restart at k=0.
    bus.in_valid = 1'b1;
    bus.input_w  = 64'h0011_0012_0013_0014;
    bus.input_n  = 64'h0011_0012_0013_0014 ^ NMASK;
    chk("e_ready", 64'(bus.in_ready), 64'h1);
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    @(posedge clk) #1;
    chk("e_word0", 64'(bus.out_w), 64'h0011_0000);
    chk("e_first", 64'(bus.out_first), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_w", 64'(bus.out_w), 64'h0);
    chk("mid_rst_out_n", 64'(bus.out_n), 64'h0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_flags", 64'({bus.out_first, bus.out_last, bus.tile_done}), 64'h0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'h1);
    bus.in_valid = 1'b1;
    bus.input_w  = 64'h0021_0022_0023_0024;
    bus.input_n  = 64'h0021_0022_0023_0024 ^ NMASK;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    @(posedge clk) #1;
    chk("f_word0", 64'(bus.out_w), 64'h0021_0000);
    chk("f_first", 64'(bus.out_first), 64'h1);
    @(posedge clk) #1;
    chk("f_lane1_first", 64'(bus.out_first), 64'h2);
    chk("f_no_last", 64'(bus.out_last), 64'h0);
    repeat (3) @(posedge clk);
    #1;

    // Four-lane build: words 0..7 pair onto lanes 0..3, lane i delayed i cycles.
    w8 = '0;
    for (int k = 0; k < 8; k++) w8[127-16*k -: 16] = 16'h0100 + 16'(k);
    b4.in_valid = 1'b1;
    b4.input_w  = w8;
    b4.input_n  = w8;
    chk("b4_ready", 64'(b4.in_ready), 64'h1);
    @(posedge clk) #1;
    b4.in_valid = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk) #1;
      for (int i = 0; i < 4; i++) begin
        logic        ev;
        logic [15:0] ed;
        ev = (t == i + 1) || (t == i + 2);
        ed = ev ? 16'h0100 + 16'(2*i + t - 1 - i) : 16'h0000;
        chk($sformatf("b4_t%0d_l%0d_vld", t, i), 64'(b4.out_valid[i]), 64'(ev));
        chk($sformatf("b4_t%0d_l%0d_dat", t, i), 64'(b4.out_w[16*(4-i)-1 -: 16]), 64'(ed));
        chk($sformatf("b4_t%0d_l%0d_fst", t, i), 64'(b4.out_first[i]), 64'(t == i + 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
